pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath and address width.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the PC value loaded at reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 redirect_valid  input  1  SHALL flag that the jump/branch stage has resolved a new fetch address.
REQ-006 redirect_addr  input  XLEN  SHALL carry the jump/branch target address.
REQ-007 stall  input  1  SHALL block new memory request issue while high.
REQ-008 imem_req_valid / imem_req_addr  output  1 / XLEN  SHALL form the instruction memory request.
REQ-009 imem_req_ready  input  1  SHALL accept the request on a cycle where valid and ready are both high.
REQ-010 imem_resp_valid / imem_resp_data  input  1 / 32  SHALL return one instruction word per accepted request, in order.
REQ-011 instr_valid / instr / instr_pc  output  1 / 32 / XLEN  SHALL present the fetched instruction and its PC to decode.
REQ-012 id_ready  input  1  SHALL consume the output on a cycle where instr_valid and id_ready are both high.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-014 IDLE: entered on reset; SHALL go to REQ on the next cycle.
REQ-015 REQ: imem_req_valid SHALL be (state==REQ) && !stall && !redirect_valid; imem_req_addr SHALL equal pc.
REQ-016 REQ: on request acceptance, SHALL go to WAIT; otherwise SHALL stay in REQ.
REQ-017 WAIT: on imem_resp_valid with discard flag clear, the block SHALL:
- register instr <= imem_resp_data;
- register instr_pc <= pc;
- set instr_valid <= 1;
- update pc <= pc + 4 (mod 2^XLEN, wrap at top of address space);
- go to HOLD.
REQ-018 WAIT: on imem_resp_valid with discard flag set, SHALL drop the data, clear the flag, and go to REQ.
REQ-019 HOLD: outputs SHALL stay stable until consumed; on consume, instr_valid SHALL fall and the FSM SHALL go to REQ.
REQ-020 Redirect in any state SHALL load pc <= redirect_addr and clear instr_valid; redirect SHALL take priority over every other event in the same cycle.
REQ-021 Redirect in REQ or HOLD: next state SHALL be REQ.
REQ-022 Redirect in WAIT without a response that cycle: SHALL set the discard flag and stay in WAIT.
REQ-023 Redirect in WAIT with a response that cycle: SHALL drop the response, leave the discard flag clear, and go to REQ.
REQ-024 stall SHALL NOT affect response capture in WAIT or holding in HOLD.
REQ-025 Latency: response captured at edge N SHALL give instr_valid=1 in cycle N+1; the next request SHALL issue no earlier than the cycle after consumption.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL set:
- pc = RESET_VECTOR;
- state = IDLE;
- discard = 0;
- instr_valid = 0;
- instr = 0;
- instr_pc = 0.
REQ-027 While in reset, imem_req_valid SHALL be 0.
REQ-028 Reset mid-transaction SHALL abandon the outstanding request; the memory side SHALL be reset in the same cycle.

Configuration
REQ-029 With FETCH_MISALIGN_TRAP_EN defined, an extra output fetch_misaligned (1 bit) SHALL exist.
- A redirect with redirect_addr[1:0]!=0 SHALL set fetch_misaligned=1 and load pc.
- The FSM SHALL then park in IDLE with no requests until reset.
- fetch_misaligned resets to 0.
REQ-030 Without FETCH_MISALIGN_TRAP_EN, the port SHALL be absent and redirect_addr[1:0] SHALL be forced to 2'b00 when loaded into pc.

Verification
REQ-031 Release reset, imem ready=1, resp 1 cycle later with 32'h0000_0013 -> first request addr 0x0, instr_valid with instr_pc=0x0, next request addr 0x4.
REQ-032 Hold id_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no imem_req_valid; id_ready=1 -> request addr pc+4 next cycle.
REQ-033 Redirect to 0x100 in WAIT, response arrives 2 cycles later -> response discarded, instr_valid stays 0, next request addr 0x100.
REQ-034 Redirect to 0x200 on the same cycle as a response -> response dropped, next request addr 0x200, discard flag 0.
REQ-035 pc=0xFFFF_FFFC, fetch completes -> next request addr 0x0000_0000.
REQ-036 Trap build: redirect to 0x102 -> fetch_misaligned=1, no further imem_req_valid; non-trap build: next request addr 0x100.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter fetch stage with a single outstanding
// instruction-memory request and a one-entry output register towards decode.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   redirect_valid, redirect_addr   resolved jump/branch target
//   stall                           blocks issue of a new memory request
//   imem_req_valid, imem_req_addr   instruction memory request (valid/ready)
//   imem_req_ready                  memory accepts the request
//   imem_resp_valid, imem_resp_data one in-order instruction word per request
//   instr_valid, instr, instr_pc    fetched instruction and its PC to decode
//   id_ready                        decode consumes the held instruction
//   fetch_misaligned                (FETCH_MISALIGN_TRAP_EN only) sticky trap
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap on a misaligned redirect
// (flag raised, fetch parked until reset). Without it the low two bits of the
// redirect target are forced to zero.
module pc_fetch_unit #(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            id_ready
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int unsigned ILEN = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            discard;
    logic            discard_nxt;
    logic            instr_valid_nxt;
    logic [ILEN-1:0] instr_nxt;
    logic [XLEN-1:0] instr_pc_nxt;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misaligned_nxt;
    logic            redirect_misaligned;

    // Target is loaded unmodified; a misaligned one raises the trap.
    assign redirect_target     = redirect_addr;
    assign redirect_misaligned = (redirect_addr[1:0] != 2'b00);
`else
    logic            unused_addr_bits;

    // Instructions are word aligned, so the low target bits are dropped.
    assign redirect_target  = {redirect_addr[XLEN-1:2], 2'b00};
    assign unused_addr_bits = ^redirect_addr[1:0];
`endif

    // Request is suppressed in reset, while stalled, and while redirecting.
    assign imem_req_valid = rst_n && (state == REQ) && !stall && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Next-state and datapath update; redirect overrides every other event.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        discard_nxt     = discard;
        instr_valid_nxt = instr_valid;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_misaligned_nxt = fetch_misaligned;
`endif

        if (redirect_valid) begin
            pc_nxt          = redirect_target;
            instr_valid_nxt = 1'b0;
            // A request still in flight must have its response thrown away.
            if ((state == WAIT) && !imem_resp_valid) begin
                discard_nxt = 1'b1;
                state_nxt   = WAIT;
            end else begin
                discard_nxt = 1'b0;
                state_nxt   = REQ;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            if (fetch_misaligned || redirect_misaligned) begin
                fetch_misaligned_nxt = 1'b1;
                discard_nxt          = 1'b0;
                state_nxt            = IDLE;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    state_nxt = fetch_misaligned ? IDLE : REQ;
`else
                    state_nxt = REQ;
`endif
                end
                REQ: begin
                    if (req_fire) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = REQ;
                        end else begin
                            instr_nxt       = imem_resp_data;
                            instr_pc_nxt    = pc;
                            instr_valid_nxt = 1'b1;
                            pc_nxt          = pc + XLEN'(4);
                            state_nxt       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_valid && id_ready) begin
                        instr_valid_nxt = 1'b0;
                        state_nxt       = REQ;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            discard     <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            discard     <= discard_nxt;
            instr_valid <= instr_valid_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_misaligned <= fetch_misaligned_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios followed by randomized traffic, checked
// against a transaction-level model of the fetch stream (expected next fetch
// address, outstanding request, held instruction).
module tb_pc_fetch_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RV   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        id_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misaligned;
`endif

    pc_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_addr   (redirect_addr),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .id_ready        (id_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model state
    logic        m_idle;
    logic        m_parked;
    logic        m_pend;
    logic        m_killed;
    logic        m_valid;
    int          m_wait;
    int          mem_delay;
    logic [31:0] m_pc;
    logic [31:0] m_pend_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        fired_now;
    logic [31:0] last_fire_addr;

    // Memory contents: address 0 holds 0x13 (nop), every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, check request, advance model,
    // clock, check registered outputs. Called in the low clock phase.
    task automatic tick();
        logic exp_req;
        logic fire;
        logic resp;
        imem_resp_valid = m_pend && (m_wait == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(m_pend_addr) : 32'($urandom());
        #1;
        exp_req = rst_n && !m_idle && !m_parked && !m_pend && !m_valid && !stall && !redirect_valid;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr, m_pc);
        fire      = exp_req && imem_req_ready;
        resp      = imem_resp_valid;
        fired_now = fire;
        if (fire) last_fire_addr = m_pc;

        if (!rst_n) begin
            m_pc = RV; m_idle = 1'b1; m_parked = 1'b0; m_pend = 1'b0; m_killed = 1'b0;
            m_wait = 0; m_valid = 1'b0; m_instr = '0; m_ipc = '0;
        end else begin
            m_idle = 1'b0;
            if (redirect_valid) begin
                m_valid  = 1'b0;
                m_killed = m_pend && !resp;
                if (resp) m_pend = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc = redirect_addr;
                if (redirect_addr[1:0] != 2'b00) m_parked = 1'b1;
`else
                m_pc = redirect_addr & 32'hFFFF_FFFC;
`endif
            end else if (fire) begin
                m_pend = 1'b1; m_pend_addr = m_pc; m_killed = 1'b0; m_wait = mem_delay;
            end else if (resp) begin
                m_pend = 1'b0;
                if (!m_killed && !m_parked) begin
                    m_valid = 1'b1; m_instr = mem_word(m_pend_addr); m_ipc = m_pend_addr;
                    m_pc = m_pend_addr + 32'd4;
                end
                m_killed = 1'b0;
            end else if (m_valid && id_ready) begin
                m_valid = 1'b0;
            end
            if (!fire && m_pend && m_wait > 0) m_wait--;
        end

        @(posedge clk);
        #1;
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("instr_pc", instr_pc, m_ipc);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fetch_misaligned", 32'(fetch_misaligned), 32'(m_parked));
`endif
        @(negedge clk);
    endtask

    task automatic run_until_fire(input logic [31:0] exp_addr, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fired_now) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_issued"}, 32'(got), 32'd1);
        if (got) chk(tag, last_fire_addr, exp_addr);
    endtask

    initial begin
        logic hit;
        checks = 0; errors = 0;
        m_pc = RV; m_idle = 1'b1; m_parked = 1'b0; m_pend = 1'b0; m_killed = 1'b0;
        m_wait = 0; m_valid = 1'b0; m_instr = '0; m_ipc = '0; mem_delay = 0;
        fired_now = 1'b0; last_fire_addr = '0;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0; stall = 1'b0;
        imem_req_ready = 1'b1; id_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0;
        @(negedge clk);

        // Reset values
        tick();
        tick();
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // First fetch from the reset vector
        rst_n = 1'b1;
        tick();
        tick();
        chk("first_req_issued", 32'(fired_now), 32'd1);
        chk("first_req_addr", last_fire_addr, 32'h0);
        tick();
        chk("first_instr", instr, 32'h0000_0013);
        chk("first_instr_pc", instr_pc, 32'h0);

        // Decode back-pressure holds the instruction and blocks issue
        repeat (5) tick();
        chk("hold_instr", instr, 32'h0000_0013);
        id_ready = 1'b1;
        tick();
        id_ready  = 1'b0;
        mem_delay = 2;
        tick();
        chk("after_consume_issued", 32'(fired_now), 32'd1);
        chk("after_consume_addr", last_fire_addr, 32'h4);

        // Redirect while waiting; late response is discarded
        redirect_valid = 1'b1; redirect_addr = 32'h100;
        tick();
        redirect_valid = 1'b0;
        mem_delay = 1;
        run_until_fire(32'h100, "redir_wait_addr");

        // Redirect in the same cycle as the response
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_pend && m_wait == 0) begin
                redirect_valid = 1'b1; redirect_addr = 32'h200;
                tick();
                redirect_valid = 1'b0;
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("redir_resp_same_cycle", 32'(hit), 32'd1);
        mem_delay = 0;
        run_until_fire(32'h200, "redir_resp_addr");
        tick();
        chk("redir_resp_captured", 32'(instr_valid), 32'd1);
        chk("redir_resp_pc", instr_pc, 32'h200);

        // Address space wrap
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        run_until_fire(32'hFFFF_FFFC, "top_addr");
        tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        run_until_fire(32'h0, "wrap_addr");

        // Misaligned redirect (response arrives in the same cycle)
        redirect_valid = 1'b1; redirect_addr = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (4) tick();
        chk("trap_flag", 32'(fetch_misaligned), 32'd1);
`else
        run_until_fire(32'h100, "misaligned_forced");
`endif

        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom % 300) != 0;
            stall          = ($urandom % 4) == 0;
            imem_req_ready = ($urandom % 3) != 0;
            id_ready       = ($urandom % 2) == 0;
            redirect_valid = ($urandom % 12) == 0;
            redirect_addr  = 32'($urandom());
            if (($urandom % 8) == 0) redirect_addr = 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            redirect_addr[1:0] = 2'b00;
`endif
            mem_delay = int'($urandom % 4);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
